// File: rtl/elite_i2c_pkg.sv
// Shared definitions for the Elite I2C register bank slice: register map,
// write-path FSM encoding, status bit positions and the status packing helper.
package elite_i2c_pkg;

    localparam logic [7:0] REG_API    = 8'd0;
    localparam logic [7:0] REG_VER    = 8'd1;
    localparam logic [7:0] REG_CMD    = 8'd2;
    localparam logic [7:0] REG_STAT   = 8'd3;
    localparam logic [7:0] REG_LEN    = 8'd4;
    localparam logic [7:0] REG_CLIP   = 8'd5;
    localparam logic [7:0] REG_ERRCNT = 8'd6;

    localparam logic [7:0] DEFAULT_HDL_VERSION = 8'h03;

    localparam int STAT_OVF_BIT   = 7;
    localparam int STAT_FULL_BIT  = 6;
    localparam int STAT_EMPTY_BIT = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_COMMIT  = 2'd2
    } bank_state_e;

    function automatic logic [7:0] pack_status(input logic ovf, input logic full,
                                               input logic empty, input logic [4:0] cnt);
        logic [7:0] s;
        s = {3'b000, cnt};
        s[STAT_OVF_BIT]   = ovf;
        s[STAT_FULL_BIT]  = full;
        s[STAT_EMPTY_BIT] = empty;
        return s;
    endfunction

endpackage

// File: rtl/elite_i2c_reg_bank_if.sv
// Bus bundle between the I2C slave / application side (master) and the
// MClk-domain register bank (slave).
interface elite_i2c_reg_bank_if;
    logic       I2C_Data_Ready;
    logic [7:0] I2C_Reg_Cmnd;
    logic [7:0] I2C_Data;
    logic [7:0] Rd_Reg_Sel;
    logic [7:0] Rd_Data;
    logic       Cmd_Valid;
    logic [7:0] Cmd_Data;
    logic       Cmd_Ready;
    logic [7:0] Data_Length;
    logic [7:0] Active_Clip;
    logic       Reg_Wr_Strobe;
    logic [2:0] Reg_Wr_Addr;

    modport master (
        output I2C_Data_Ready, I2C_Reg_Cmnd, I2C_Data, Rd_Reg_Sel, Cmd_Ready,
        input  Rd_Data, Cmd_Valid, Cmd_Data, Data_Length, Active_Clip,
               Reg_Wr_Strobe, Reg_Wr_Addr
    );

    modport slave (
        input  I2C_Data_Ready, I2C_Reg_Cmnd, I2C_Data, Rd_Reg_Sel, Cmd_Ready,
        output Rd_Data, Cmd_Valid, Cmd_Data, Data_Length, Active_Clip,
               Reg_Wr_Strobe, Reg_Wr_Addr
    );
endinterface

// File: rtl/elite_cmd_fifo.sv
// Synchronous show-ahead command FIFO with occupancy count, full and empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module elite_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty = (count_r == {CW{1'b0}});
    assign full  = (count_r == CW'(DEPTH));
    // A pop frees a slot in the same cycle, so a push into a full FIFO is legal then
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    // Storage and read/write pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
        end
    end

    // Occupancy count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
        end else begin
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign count   = count_r;

endmodule

// File: rtl/elite_i2c_reg_bank.sv
// MClk-domain register bank behind the Elite I2C slave write path.
// Define REG_BANK_ERR_CNT_EN to add the rejected-write counter at index 6.
module elite_i2c_reg_bank
    import elite_i2c_pkg::*;
#(
    parameter logic [7:0] HDL_VERSION    = DEFAULT_HDL_VERSION,
    parameter int         CMD_FIFO_DEPTH = 4
) (
    input  logic                MClk,
    input  logic                Rst_Flag,
    elite_i2c_reg_bank_if.slave bus
);
    localparam int CNT_W = $clog2(CMD_FIFO_DEPTH) + 1;

    logic             sync1_r, sync2_r, sync3_r;
    logic             edge_s;
    bank_state_e      state_r, state_nxt_s;
    logic [7:0]       cmd_r, data_r;
    logic [7:0]       reg0_r, reg2_r, reg4_r, reg5_r;
    logic             ovf_r;
    logic             strobe_r;
    logic [2:0]       wr_addr_r;
    logic [7:0]       rd_data_r;
    logic             accept_s, wr_reg0_s, wr_reg2_s, wr_reg4_s, wr_reg5_s, clr_ovf_s;
    logic             pop_s;
    logic [7:0]       fifo_head_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic             fifo_full_s, fifo_empty_s;
    logic [7:0]       status_s, rd_mux_s;
`ifdef REG_BANK_ERR_CNT_EN
    logic             clr_err_s, reject_s;
    logic [7:0]       err_cnt_r;
`endif

    // Bring the SCL-domain ready flag into MClk; third stage feeds the edge detect
    always_ff @(posedge MClk or posedge Rst_Flag) begin
        if (Rst_Flag) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= bus.I2C_Data_Ready;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    assign edge_s = sync2_r & ~sync3_r;

    // Write-path state register
    always_ff @(posedge MClk or posedge Rst_Flag) begin
        if (Rst_Flag) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; edges outside IDLE are dropped
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (edge_s) begin
                    state_nxt_s = ST_CAPTURE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CAPTURE: state_nxt_s = ST_COMMIT;
            ST_COMMIT:  state_nxt_s = ST_IDLE;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // Latch index and data while the slave holds them stable
    always_ff @(posedge MClk or posedge Rst_Flag) begin
        if (Rst_Flag) begin
            cmd_r  <= 8'h00;
            data_r <= 8'h00;
        end else if (state_r == ST_CAPTURE) begin
            cmd_r  <= bus.I2C_Reg_Cmnd;
            data_r <= bus.I2C_Data;
        end
    end

    // Decode the captured write during COMMIT
    always_comb begin
        accept_s  = 1'b0;
        wr_reg0_s = 1'b0;
        wr_reg2_s = 1'b0;
        wr_reg4_s = 1'b0;
        wr_reg5_s = 1'b0;
        clr_ovf_s = 1'b0;
`ifdef REG_BANK_ERR_CNT_EN
        clr_err_s = 1'b0;
`endif
        if (state_r == ST_COMMIT) begin
            case (cmd_r)
                REG_API:  begin accept_s = 1'b1; wr_reg0_s = 1'b1; end
                REG_CMD:  begin accept_s = 1'b1; wr_reg2_s = 1'b1; end
                REG_STAT: begin accept_s = 1'b1; clr_ovf_s = data_r[STAT_OVF_BIT]; end
                REG_LEN:  begin accept_s = 1'b1; wr_reg4_s = 1'b1; end
                REG_CLIP: begin accept_s = 1'b1; wr_reg5_s = 1'b1; end
`ifdef REG_BANK_ERR_CNT_EN
                REG_ERRCNT: begin accept_s = 1'b1; clr_err_s = 1'b1; end
`endif
                default:  accept_s = 1'b0;
            endcase
        end else begin
            accept_s = 1'b0;
        end
    end

    assign pop_s = bus.Cmd_Ready & ~fifo_empty_s;

    // Register bank, overflow flag and commit strobe
    always_ff @(posedge MClk or posedge Rst_Flag) begin
        if (Rst_Flag) begin
            reg0_r    <= 8'h00;
            reg2_r    <= 8'h00;
            reg4_r    <= 8'h00;
            reg5_r    <= 8'h00;
            ovf_r     <= 1'b0;
            strobe_r  <= 1'b0;
            wr_addr_r <= 3'd0;
        end else begin
            if (wr_reg0_s) reg0_r <= data_r;
            if (wr_reg2_s) reg2_r <= data_r;
            if (wr_reg4_s) reg4_r <= data_r;
            if (wr_reg5_s) reg5_r <= data_r;
            if (clr_ovf_s) begin
                ovf_r <= 1'b0;
            end else if (wr_reg2_s && fifo_full_s && !pop_s) begin
                ovf_r <= 1'b1;
            end
            strobe_r <= accept_s;
            if (accept_s) wr_addr_r <= cmd_r[2:0];
        end
    end

`ifdef REG_BANK_ERR_CNT_EN
    assign reject_s = (state_r == ST_COMMIT) & ~accept_s;

    // Saturating count of rejected writes
    always_ff @(posedge MClk or posedge Rst_Flag) begin
        if (Rst_Flag) begin
            err_cnt_r <= 8'h00;
        end else if (clr_err_s) begin
            err_cnt_r <= 8'h00;
        end else if (reject_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'h01;
        end
    end
`endif

    elite_cmd_fifo #(
        .DEPTH (CMD_FIFO_DEPTH),
        .WIDTH (8)
    ) u_cmd_fifo (
        .clk     (MClk),
        .rst     (Rst_Flag),
        .push    (wr_reg2_s),
        .pop     (pop_s),
        .wr_data (data_r),
        .rd_data (fifo_head_s),
        .count   (fifo_count_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    assign status_s = pack_status(ovf_r, fifo_full_s, fifo_empty_s, 5'(fifo_count_s));

    // Read-back mux
    always_comb begin
        rd_mux_s = 8'h00;
        case (bus.Rd_Reg_Sel)
            REG_API:    rd_mux_s = reg0_r;
            REG_VER:    rd_mux_s = HDL_VERSION;
            REG_CMD:    rd_mux_s = reg2_r;
            REG_STAT:   rd_mux_s = status_s;
            REG_LEN:    rd_mux_s = reg4_r;
            REG_CLIP:   rd_mux_s = reg5_r;
`ifdef REG_BANK_ERR_CNT_EN
            REG_ERRCNT: rd_mux_s = err_cnt_r;
`endif
            default:    rd_mux_s = 8'h00;
        endcase
    end

    // Registered read data
    always_ff @(posedge MClk or posedge Rst_Flag) begin
        if (Rst_Flag) begin
            rd_data_r <= 8'h00;
        end else begin
            rd_data_r <= rd_mux_s;
        end
    end

    assign bus.Rd_Data       = rd_data_r;
    assign bus.Cmd_Valid     = ~fifo_empty_s;
    assign bus.Cmd_Data      = fifo_head_s;
    assign bus.Data_Length   = reg4_r;
    assign bus.Active_Clip   = reg5_r;
    assign bus.Reg_Wr_Strobe = strobe_r;
    assign bus.Reg_Wr_Addr   = wr_addr_r;

endmodule

// File: tb/tb_elite_i2c_reg_bank.sv
// Self-checking bench for elite_i2c_reg_bank: directed vector table, multi-cycle
// corner sequences and randomized writes against a register-map reference model.
module tb_elite_i2c_reg_bank;
    import elite_i2c_pkg::*;

    logic MClk = 1'b0;
    logic Rst_Flag;
    int   checks   = 0;
    int   failures = 0;

    elite_i2c_reg_bank_if bus ();

    elite_i2c_reg_bank #(
        .HDL_VERSION    (8'h03),
        .CMD_FIFO_DEPTH (4)
    ) dut (
        .MClk     (MClk),
        .Rst_Flag (Rst_Flag),
        .bus      (bus)
    );

    always #10 MClk = ~MClk;

    // Reference model: register contents, command queue, sticky overflow, error count
    logic [7:0] m_reg [0:5];
    logic [7:0] m_q [$];
    bit         m_ovf;
    int         m_err;

    function automatic void model_reset();
        for (int i = 0; i < 6; i++) m_reg[i] = 8'h00;
        m_q.delete();
        m_ovf = 1'b0;
        m_err = 0;
    endfunction

    function automatic bit model_write(input logic [7:0] idx, input logic [7:0] dat, input bit pop_same);
        bit acc;
        acc = 1'b1;
        if (pop_same && m_q.size() > 0) void'(m_q.pop_front());
        case (idx)
            8'd0, 8'd4, 8'd5: m_reg[idx[2:0]] = dat;
            8'd2: begin
                m_reg[2] = dat;
                if (m_q.size() < 4) m_q.push_back(dat);
                else m_ovf = 1'b1;
            end
            8'd3: if (dat[7]) m_ovf = 1'b0;
`ifdef REG_BANK_ERR_CNT_EN
            8'd6: m_err = 0;
`endif
            default: acc = 1'b0;
        endcase
        if (!acc && m_err < 255) m_err++;
        return acc;
    endfunction

    function automatic logic [7:0] model_read(input logic [7:0] idx);
        case (idx)
            8'd0, 8'd2, 8'd4, 8'd5: return m_reg[idx[2:0]];
            8'd1: return 8'h03;
            8'd3: return {m_ovf, m_q.size() == 4, m_q.size() == 0, 5'(m_q.size())};
`ifdef REG_BANK_ERR_CNT_EN
            8'd6: return 8'(m_err);
`endif
            default: return 8'h00;
        endcase
    endfunction

    task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Raise the ready flag for 'hold' cycles and record any strobe pulses
    task automatic do_write(input logic [7:0] idx, input logic [7:0] dat, input int hold,
                            input bit pop_same, output int cnt, output int cyc, output logic [2:0] addr);
        cnt  = 0;
        cyc  = -1;
        addr = 3'd0;
        @(negedge MClk);
        bus.I2C_Reg_Cmnd   = idx;
        bus.I2C_Data       = dat;
        bus.I2C_Data_Ready = 1'b1;
        for (int c = 1; c <= hold + 6; c++) begin
            @(negedge MClk);
            if (bus.Reg_Wr_Strobe) begin
                cnt++;
                if (cyc < 0) begin
                    cyc  = c;
                    addr = bus.Reg_Wr_Addr;
                end
            end
            if (c == hold) bus.I2C_Data_Ready = 1'b0;
            if (pop_same && c == 4) bus.Cmd_Ready = 1'b1;
            if (c == 5) bus.Cmd_Ready = 1'b0;
        end
    endtask

    task automatic write_chk(input logic [7:0] idx, input logic [7:0] dat, input bit pop_same);
        int cnt, cyc;
        logic [2:0] addr;
        bit exp;
        do_write(idx, dat, 12, pop_same, cnt, cyc, addr);
        exp = model_write(idx, dat, pop_same);
        check_int("strobe_count", cnt, exp ? 1 : 0);
        if (exp) begin
            check_int("strobe_cycle", cyc, 5);
            check8("strobe_addr", {5'b00000, addr}, idx);
        end
    endtask

    task automatic read_chk(input logic [7:0] idx, input logic [7:0] exp, input string nm);
        bus.Rd_Reg_Sel = idx;
        @(negedge MClk);
        check8(nm, bus.Rd_Data, exp);
    endtask

    task automatic pop_chk(input string nm);
        check8({nm, "_valid"}, {7'b0000000, bus.Cmd_Valid}, {7'b0000000, m_q.size() > 0});
        if (m_q.size() > 0) check8({nm, "_head"}, bus.Cmd_Data, m_q[0]);
        bus.Cmd_Ready = 1'b1;
        @(negedge MClk);
        bus.Cmd_Ready = 1'b0;
        if (m_q.size() > 0) void'(m_q.pop_front());
    endtask

    typedef struct {
        logic [7:0] idx;
        logic [7:0] data;
        int         hold;
        int         exp_stb;
        logic [2:0] exp_addr;
        logic [7:0] rd_idx;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int cnt, cyc;
        logic [2:0] addr;

        tbl[0] = '{8'd4,   8'h5A, 500, 1, 3'd4, 8'd4,   8'h5A};
        tbl[1] = '{8'd1,   8'hFF, 12,  0, 3'd0, 8'd1,   8'h03};
        tbl[2] = '{8'd0,   8'hA5, 12,  1, 3'd0, 8'd0,   8'hA5};
        tbl[3] = '{8'd5,   8'h3C, 12,  1, 3'd5, 8'd5,   8'h3C};
        tbl[4] = '{8'd7,   8'h77, 12,  0, 3'd0, 8'd7,   8'h00};
`ifdef REG_BANK_ERR_CNT_EN
        tbl[5] = '{8'd6,   8'h66, 12,  1, 3'd6, 8'd6,   8'h00};
`else
        tbl[5] = '{8'd6,   8'h66, 12,  0, 3'd0, 8'd6,   8'h00};
`endif
        tbl[6] = '{8'hFF,  8'h12, 12,  0, 3'd0, 8'hFF,  8'h00};
        tbl[7] = '{8'd3,   8'h00, 12,  1, 3'd3, 8'd3,   8'h20};

        bus.I2C_Data_Ready = 1'b0;
        bus.I2C_Reg_Cmnd   = 8'h00;
        bus.I2C_Data       = 8'h00;
        bus.Rd_Reg_Sel     = 8'h00;
        bus.Cmd_Ready      = 1'b0;
        Rst_Flag           = 1'b1;
        model_reset();
        repeat (3) @(negedge MClk);

        check8("rst_rd_data", bus.Rd_Data, 8'h00);
        check8("rst_cmd_valid", {7'b0000000, bus.Cmd_Valid}, 8'h00);
        check8("rst_cmd_data", bus.Cmd_Data, 8'h00);
        check8("rst_strobe", {7'b0000000, bus.Reg_Wr_Strobe}, 8'h00);
        check8("rst_wr_addr", {5'b00000, bus.Reg_Wr_Addr}, 8'h00);
        check8("rst_data_length", bus.Data_Length, 8'h00);
        check8("rst_active_clip", bus.Active_Clip, 8'h00);
        Rst_Flag = 1'b0;
        @(negedge MClk);
        read_chk(8'd1, 8'h03, "rst_reg1");
        read_chk(8'd3, 8'h20, "rst_status");

        // Directed register-map vectors
        for (int i = 0; i < 8; i++) begin
            do_write(tbl[i].idx, tbl[i].data, tbl[i].hold, 1'b0, cnt, cyc, addr);
            void'(model_write(tbl[i].idx, tbl[i].data, 1'b0));
            check_int($sformatf("tbl%0d_strobe_count", i), cnt, tbl[i].exp_stb);
            if (tbl[i].exp_stb != 0) begin
                check_int($sformatf("tbl%0d_strobe_cycle", i), cyc, 5);
                check8($sformatf("tbl%0d_strobe_addr", i), {5'b00000, addr}, {5'b00000, tbl[i].exp_addr});
            end
            read_chk(tbl[i].rd_idx, tbl[i].exp_rd, $sformatf("tbl%0d_read", i));
            check8($sformatf("tbl%0d_data_length", i), bus.Data_Length, m_reg[4]);
            check8($sformatf("tbl%0d_active_clip", i), bus.Active_Clip, m_reg[5]);
`ifdef REG_BANK_ERR_CNT_EN
            read_chk(REG_ERRCNT, model_read(REG_ERRCNT), $sformatf("tbl%0d_errcnt", i));
`endif
        end

        // Overflow: five pushes into a four-deep FIFO with no consumer
        for (int k = 0; k < 5; k++) write_chk(REG_CMD, 8'(8'h11 + k), 1'b0);
        read_chk(REG_STAT, 8'hC4, "ovf_status");
        read_chk(REG_CMD, 8'h15, "ovf_reg2");
        check8("ovf_head", bus.Cmd_Data, 8'h11);
        check8("ovf_valid", {7'b0000000, bus.Cmd_Valid}, 8'h01);

        // Drain in order, then clear the sticky overflow
        for (int k = 0; k < 4; k++) begin
            check8($sformatf("drain%0d_head", k), bus.Cmd_Data, 8'(8'h11 + k));
            pop_chk("drain");
        end
        read_chk(REG_STAT, 8'hA0, "drained_status");
        write_chk(REG_STAT, 8'h80, 1'b0);
        read_chk(REG_STAT, 8'h20, "ovf_cleared_status");

        // Full FIFO with push and pop in the same cycle
        for (int k = 0; k < 4; k++) write_chk(REG_CMD, 8'(8'h21 + k), 1'b0);
        read_chk(REG_STAT, 8'h44, "full_status");
        write_chk(REG_CMD, 8'h25, 1'b1);
        read_chk(REG_STAT, 8'h44, "pushpop_status");
        check8("pushpop_head", bus.Cmd_Data, 8'h22);
        read_chk(REG_CMD, 8'h25, "pushpop_reg2");

        // Reset while the write is in CAPTURE; the still-high flag commits after release
        check8("rstmid_clip_before", bus.Active_Clip, 8'h3C);
        @(negedge MClk);
        bus.I2C_Reg_Cmnd   = REG_CLIP;
        bus.I2C_Data       = 8'h99;
        bus.I2C_Data_Ready = 1'b1;
        repeat (3) @(negedge MClk);
        Rst_Flag = 1'b1;
        @(negedge MClk);
        check8("rstmid_clip_in_reset", bus.Active_Clip, 8'h00);
        check8("rstmid_strobe_in_reset", {7'b0000000, bus.Reg_Wr_Strobe}, 8'h00);
        check8("rstmid_valid_in_reset", {7'b0000000, bus.Cmd_Valid}, 8'h00);
        Rst_Flag = 1'b0;
        model_reset();
        cnt = 0;
        cyc = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge MClk);
            if (c == 4) check8("rstmid_clip_pre_commit", bus.Active_Clip, 8'h00);
            if (bus.Reg_Wr_Strobe) begin
                cnt++;
                if (cyc < 0) cyc = c;
            end
        end
        bus.I2C_Data_Ready = 1'b0;
        repeat (6) @(negedge MClk);
        void'(model_write(REG_CLIP, 8'h99, 1'b0));
        check_int("rstmid_strobe_count", cnt, 1);
        check_int("rstmid_strobe_cycle", cyc, 5);
        check8("rstmid_clip_after", bus.Active_Clip, 8'h99);

        // Randomized writes, pops and full read-back sweeps against the model
        for (int n = 0; n < 25; n++) begin
            logic [7:0] ridx;
            logic [7:0] rdat;
            ridx = ($urandom_range(0, 2) == 0) ? REG_CMD : 8'($urandom_range(0, 8));
            rdat = 8'($urandom);
            write_chk(ridx, rdat, 1'($urandom_range(0, 1)));
            for (int r = 0; r < 8; r++) read_chk(8'(r), model_read(8'(r)), $sformatf("rnd%0d_read%0d", n, r));
            check8("rnd_data_length", bus.Data_Length, m_reg[4]);
            check8("rnd_active_clip", bus.Active_Clip, m_reg[5]);
            repeat ($urandom_range(0, 2)) pop_chk("rnd_pop");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
